// File: rtl/q8_16_alu.sv
// ---------------------------------------------------------------------------
// q8_16_alu
//   Signed Q8.16 fixed-point ALU (24-bit two's complement, 16 fraction bits).
//   Computes add / sub / mul / div of the two operands every cycle and
//   registers a saturated result together with overflow and divide-by-zero
//   flags. One operation is accepted per clock; latency is one cycle.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset (clears all outputs)
//   a            in   24  signed Q8.16 operand A
//   b            in   24  signed Q8.16 operand B
//   aluop        in   2   00 add, 01 sub, 10 mul, 11 div
//   result       out  24  registered, saturated Q8.16 result
//   overflow     out  1   registered; exact result was clamped
//   div_by_zero  out  1   registered; division with b == 0
// ---------------------------------------------------------------------------
module q8_16_alu #(
    parameter int W    = 24,
    parameter int FRAC = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   aluop,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         div_by_zero
);

    localparam int WW = 2 * W;        // common width all candidates are widened to
    localparam int DW = W + FRAC + 1; // divider width; the extra bit holds +2^39

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic signed [WW-1:0] SAT_MAX = {{(WW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_MIN = {{(WW-W+1){1'b1}}, {(W-1){1'b0}}};

    // Exact-width arithmetic candidates
    logic signed [W:0]    w_sum;
    logic signed [W:0]    w_diff;
    logic signed [WW-1:0] w_prod;
    logic signed [WW-1:0] w_prod_sh;
    logic signed [DW-1:0] w_dividend;
    logic signed [DW-1:0] w_divisor;
    logic signed [DW-1:0] w_quot;
    logic                 w_b_zero;

    logic signed [WW-1:0] w_wide;
    logic [W-1:0]         w_result;
    logic                 w_ovf;
    logic                 w_dbz;

    assign w_sum  = {a[W-1], a} + {b[W-1], b};
    assign w_diff = {a[W-1], a} - {b[W-1], b};

    // Product is Q16.32; arithmetic shift drops 16 fraction bits (floor).
    assign w_prod    = $signed(a) * $signed(b);
    assign w_prod_sh = w_prod >>> FRAC;

    // Dividend is a scaled by 2^16 so the integer quotient lands in Q8.16.
    // One guard bit keeps -2^39 / -1 representable before saturation.
    // A zero divisor is replaced by 1 so the divider never sees 0; its
    // quotient is ignored in that case.
    assign w_b_zero   = (b == '0);
    assign w_dividend = {a[W-1], a, {FRAC{1'b0}}};
    assign w_divisor  = w_b_zero ? DW'(1) : {{(DW-W){b[W-1]}}, b};
    assign w_quot     = w_dividend / w_divisor; // signed: truncates toward zero

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_wide   = '0;
        w_result = '0;
        w_ovf    = 1'b0;
        w_dbz    = 1'b0;

        case (aluop)
            OP_ADD:  w_wide = {{(WW-W-1){w_sum[W]}}, w_sum};
            OP_SUB:  w_wide = {{(WW-W-1){w_diff[W]}}, w_diff};
            OP_MUL:  w_wide = w_prod_sh;
            default: w_wide = {{(WW-DW){w_quot[DW-1]}}, w_quot};
        endcase

        if (aluop == OP_DIV && w_b_zero) begin
            // Divide by zero saturates toward the sign of a; not an overflow.
            w_result = a[W-1] ? SAT_MIN[W-1:0] : SAT_MAX[W-1:0];
            w_dbz    = 1'b1;
        end else if (w_wide > SAT_MAX) begin
            w_result = SAT_MAX[W-1:0];
            w_ovf    = 1'b1;
        end else if (w_wide < SAT_MIN) begin
            w_result = SAT_MIN[W-1:0];
            w_ovf    = 1'b1;
        end else begin
            w_result = w_wide[W-1:0];
        end
    end

    // NOTE: registered state uses non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result      <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            result      <= w_result;
            overflow    <= w_ovf;
            div_by_zero <= w_dbz;
        end
    end

endmodule

// File: tb/tb_q8_16_alu.sv
// ---------------------------------------------------------------------------
// tb_q8_16_alu
//   Directed self-checking bench for q8_16_alu. Each scenario task drives
//   hand-computed vectors and compares result/overflow/div_by_zero inline.
// ---------------------------------------------------------------------------
module tb_q8_16_alu;

    logic        clk;
    logic        rst_n;
    logic [23:0] a;
    logic [23:0] b;
    logic [1:0]  aluop;
    logic [23:0] result;
    logic        overflow;
    logic        div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [23:0] a;
        logic [23:0] b;
        logic [1:0]  op;
        logic [23:0] r;
        logic        o;
        logic        d;
    } vec_t;

    q8_16_alu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .aluop       (aluop),
        .result      (result),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands on the falling edge, then sample 1 ns after the rising edge.
    task automatic do_op(input logic [23:0] ia, input logic [23:0] ib, input logic [1:0] iop);
        @(negedge clk);
        a     = ia;
        b     = ib;
        aluop = iop;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a     = 24'h100000;
        b     = 24'h010000;
        aluop = 2'b00;
        #2;
        n_tests++;
        if ({result, overflow, div_by_zero} !== {24'h000000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: got r=%h o=%b d=%b, expected r=000000 o=0 d=0",
                     result, overflow, div_by_zero);
        end
        // Clock edges while held in reset must not load anything.
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({result, overflow, div_by_zero} !== {24'h000000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hold: got r=%h o=%b d=%b, expected r=000000 o=0 d=0",
                     result, overflow, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_table(input string tag, input vec_t v [], input int n);
        for (int i = 0; i < n; i++) begin
            do_op(v[i].a, v[i].b, v[i].op);
            n_tests++;
            if ({result, overflow, div_by_zero} !== {v[i].r, v[i].o, v[i].d}) begin
                n_fail++;
                $display("FAIL %s[%0d] a=%h b=%h op=%b: got r=%h o=%b d=%b, expected r=%h o=%b d=%b",
                         tag, i, v[i].a, v[i].b, v[i].op, result, overflow, div_by_zero,
                         v[i].r, v[i].o, v[i].d);
            end
        end
    endtask

    task automatic test_add_sub();
        vec_t v [];
        v = new[6];
        v[0] = '{24'h100000, 24'h800000, 2'b00, 24'h900000, 1'b0, 1'b0}; // 16 + -128 = -112
        v[1] = '{24'h100000, 24'h800000, 2'b01, 24'h7FFFFF, 1'b1, 1'b0}; // 144 clamps high
        v[2] = '{24'h7FFFFF, 24'h000001, 2'b00, 24'h7FFFFF, 1'b1, 1'b0}; // max + lsb
        v[3] = '{24'h7FFFFF, 24'h000000, 2'b00, 24'h7FFFFF, 1'b0, 1'b0}; // exactly max
        v[4] = '{24'h800000, 24'h000001, 2'b01, 24'h800000, 1'b1, 1'b0}; // min - lsb
        v[5] = '{24'h018000, 24'h020000, 2'b01, 24'hFF8000, 1'b0, 1'b0}; // 1.5 - 2 = -0.5
        run_table("add_sub", v, 6);
    endtask

    task automatic test_mul();
        vec_t v [];
        v = new[6];
        v[0] = '{24'h100000, 24'h800000, 2'b10, 24'h800000, 1'b1, 1'b0}; // -2048 clamps low
        v[1] = '{24'h018000, 24'h020000, 2'b10, 24'h030000, 1'b0, 1'b0}; // 1.5 * 2 = 3
        v[2] = '{24'hFFFFFF, 24'h000001, 2'b10, 24'hFFFFFF, 1'b0, 1'b0}; // floor of -2^-32
        v[3] = '{24'hFFFFFF, 24'hFFFFFF, 2'b10, 24'h000000, 1'b0, 1'b0}; // +2^-32 floors to 0
        v[4] = '{24'h800000, 24'h800000, 2'b10, 24'h7FFFFF, 1'b1, 1'b0}; // 16384 clamps high
        v[5] = '{24'h800000, 24'h010000, 2'b10, 24'h800000, 1'b0, 1'b0}; // -128 * 1 exact
        run_table("mul", v, 6);
    endtask

    task automatic test_div();
        vec_t v [];
        v = new[8];
        v[0] = '{24'h100000, 24'h800000, 2'b11, 24'hFFE000, 1'b0, 1'b0}; // 16 / -128 = -0.125
        v[1] = '{24'h800000, 24'hFF0000, 2'b11, 24'h7FFFFF, 1'b1, 1'b0}; // -128 / -1
        v[2] = '{24'h100000, 24'h000000, 2'b11, 24'h7FFFFF, 1'b0, 1'b1}; // /0, a > 0
        v[3] = '{24'hF00000, 24'h000000, 2'b11, 24'h800000, 1'b0, 1'b1}; // /0, a < 0
        v[4] = '{24'h000000, 24'h000000, 2'b11, 24'h7FFFFF, 1'b0, 1'b1}; // /0, a == 0
        v[5] = '{24'hFFFFFF, 24'h020000, 2'b11, 24'h000000, 1'b0, 1'b0}; // -2^-17 truncs to 0
        v[6] = '{24'h800000, 24'hFFFFFF, 2'b11, 24'h7FFFFF, 1'b1, 1'b0}; // -128 / -2^-16
        v[7] = '{24'h800000, 24'h000001, 2'b11, 24'h800000, 1'b1, 1'b0}; // -128 / +2^-16
        run_table("div", v, 8);
    endtask

    // Consecutive ops with no idle cycles; also checks outputs hold mid-cycle.
    task automatic test_back_to_back();
        vec_t v [];
        v = new[4];
        v[0] = '{24'h018000, 24'h020000, 2'b00, 24'h038000, 1'b0, 1'b0}; // 1.5 + 2 = 3.5
        v[1] = '{24'h100000, 24'h000000, 2'b11, 24'h7FFFFF, 1'b0, 1'b1};
        v[2] = '{24'h018000, 24'h020000, 2'b10, 24'h030000, 1'b0, 1'b0};
        v[3] = '{24'h100000, 24'h800000, 2'b01, 24'h7FFFFF, 1'b1, 1'b0};
        run_table("b2b", v, 4);
        #3; // still before the next falling edge; inputs unchanged, outputs held
        n_tests++;
        if ({result, overflow, div_by_zero} !== {24'h7FFFFF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_hold: got r=%h o=%b d=%b, expected r=7fffff o=1 d=0",
                     result, overflow, div_by_zero);
        end
    endtask

    task automatic test_mid_reset();
        do_op(24'h100000, 24'h000000, 2'b11); // leaves div_by_zero set
        @(negedge clk);
        a     = 24'h018000;
        b     = 24'h020000;
        aluop = 2'b10;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({result, overflow, div_by_zero} !== {24'h000000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_async: got r=%h o=%b d=%b, expected r=000000 o=0 d=0",
                     result, overflow, div_by_zero);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if ({result, overflow, div_by_zero} !== {24'h000000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_edge: got r=%h o=%b d=%b, expected r=000000 o=0 d=0",
                     result, overflow, div_by_zero);
        end
        #2;
        rst_n = 1'b1; // released between edges
        @(posedge clk);
        #1;
        n_tests++;
        if ({result, overflow, div_by_zero} !== {24'h030000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_release: got r=%h o=%b d=%b, expected r=030000 o=0 d=0",
                     result, overflow, div_by_zero);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
